// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first: recovers bytes from i_rx and strobes them out.
// o_Byte is loaded at the last data bit so it is stable a full bit time before o_ready_read.
module uart_rx_byte #(
  parameter int CLK_FREQ  = 10_000_000,
  parameter int BAUD_RATE = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_Byte,
  output logic       o_ready_read,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_rx_meta;
  logic          r_rx_s;
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_next;
  logic [7:0]    r_shreg;
  logic [7:0]    w_shreg_next;
  logic [7:0]    r_byte;
  logic [7:0]    w_byte_next;
  logic          r_ready;
  logic          w_ready_next;
  logic          r_ferr;
  logic          w_ferr_next;
  logic          r_busy;
  logic          w_busy_next;

  // Idle-high synchronizer so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_byte  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shreg <= w_shreg_next;
      r_byte  <= w_byte_next;
      r_ready <= w_ready_next;
      r_ferr  <= w_ferr_next;
      r_busy  <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    w_shreg_next = r_shreg;
    w_byte_next  = r_byte;
    w_ready_next = 1'b0;
    w_ferr_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (!r_rx_s) w_state_next = S_START;
      end
      S_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (r_cnt == C_HALF) begin
          w_cnt_next = '0;
          w_idx_next = '0;
          w_state_next = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_next = '0;
          w_shreg_next[r_idx] = r_rx_s;
          if (r_idx == 3'd7) begin
            w_byte_next  = {r_rx_s, r_shreg[6:0]};
            w_state_next = S_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == C_LAST) begin
          w_cnt_next = '0;
          if (r_rx_s) begin
            w_ready_next = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must go high before another start can be recognised.
        w_cnt_next = '0;
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != S_IDLE);
  end

  assign o_Byte       = r_byte;
  assign o_ready_read = r_ready;
  assign o_frame_err  = r_ferr;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: serial frames driven at pin level, expected strobes queued per
// frame and checked by a single negedge compare process.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int CPB   = 10;
  localparam int TCLK  = 10;
  localparam int NOMBIT = CPB * TCLK;

  logic       clk;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_Byte;
  logic       o_ready_read;
  logic       o_frame_err;
  logic       o_busy;

  uart_rx_byte #(.CLK_FREQ(10_000_000), .BAUD_RATE(1_000_000)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_Byte      (o_Byte),
    .o_ready_read(o_ready_read),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #(TCLK/2) clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    longint     ts;
    bit         chk_lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endfunction

  // Compare process: every strobe must match the oldest queued frame outcome.
  logic [7:0] prev_byte   = 8'h00;
  int         stable      = 0;
  bit         prev_strobe = 1'b0;

  always @(negedge clk) begin
    exp_t   e;
    longint lat;
    if (o_Byte !== prev_byte) stable = 0;
    else stable++;
    prev_byte = o_Byte;
    if (o_ready_read || o_frame_err) begin
      chk(!(o_ready_read && o_frame_err), "strobes_exclusive", {o_ready_read, o_frame_err}, 0);
      chk(!prev_strobe, "strobe_one_cycle", prev_strobe, 0);
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_strobe", {o_ready_read, o_frame_err}, 0);
      end else begin
        e = q.pop_front();
        chk(o_frame_err == e.is_err, "strobe_kind_err", o_frame_err, e.is_err);
        chk(o_Byte === e.b, "byte_value", o_Byte, e.b);
        if (!e.is_err) chk(stable >= CPB, "byte_stable", stable, CPB);
        if (e.chk_lat) begin
          // Start edge sits 7 ns before the sampling posedge; strobe is seen 5 ns after its edge.
          lat = ($time - e.ts - 12) / TCLK;
          chk(lat >= 96 && lat <= 98, "latency", lat, 97);
        end
        $display("rx %s byte=%02h expected=%02h t=%0t", o_frame_err ? "ferr " : "ready", o_Byte, e.b, $time);
      end
    end
    prev_strobe = o_ready_read || o_frame_err;
  end

  // Place the next start edge 3 ns after a posedge, clear of both clock edges.
  task automatic align();
    @(posedge clk);
    #3;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bitp, input bit stop_val);
    logic [9:0] bits;
    exp_t e;
    bits      = {stop_val, b, 1'b0};
    e.is_err  = !stop_val;
    e.b       = b;
    e.ts      = $time;
    e.chk_lat = (bitp == NOMBIT) && stop_val;
    q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      i_rx = bits[i];
      if (i == 5) begin
        #(bitp/2);
        chk(o_busy == 1'b1, "busy_mid_frame", o_busy, 1);
        #(bitp - bitp/2);
      end else begin
        #(bitp);
      end
    end
    i_rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 300 && q.size() != 0; c++) @(negedge clk);
    chk(q.size() == 0, name, q.size(), 0);
    q.delete();
    repeat (4) @(negedge clk);
    chk(o_busy == 1'b0, "busy_idle_after", o_busy, 0);
  endtask

  initial begin
    int bp;
    int gap;
    logic [7:0] rb;
    logic [9:0] bits;

    i_rx    = 1'b1;
    i_reset = 1'b0;
    #23;
    chk(o_Byte == 8'h00, "reset_byte", o_Byte, 0);
    chk(o_ready_read == 1'b0, "reset_ready", o_ready_read, 0);
    chk(o_frame_err == 1'b0, "reset_ferr", o_frame_err, 0);
    chk(o_busy == 1'b0, "reset_busy", o_busy, 0);
    align();
    i_reset = 1'b1;
    repeat (5) @(posedge clk);

    // 1: single nominal frame
    align();
    send_frame(8'hA5, NOMBIT, 1'b1);
    wait_drain("drain_a5");
    chk(o_Byte == 8'hA5, "held_byte_a5", o_Byte, 8'hA5);

    // 2: back-to-back frames
    align();
    send_frame(8'h31, NOMBIT, 1'b1);
    send_frame(8'h7F, NOMBIT, 1'b1);
    wait_drain("drain_b2b");

    // 3: short glitch is ignored
    align();
    i_rx = 1'b0;
    #(3*TCLK);
    i_rx = 1'b1;
    #(11*TCLK);
    chk(o_busy == 1'b0, "glitch_idle", o_busy, 0);
    chk(q.size() == 0, "glitch_no_event", q.size(), 0);
    repeat (100) @(negedge clk);

    // 4: framing error, held break, recovery
    align();
    send_frame(8'h55, NOMBIT, 1'b0);
    i_rx = 1'b0;
    #(30*TCLK);
    chk(o_busy == 1'b1, "busy_in_break", o_busy, 1);
    chk(q.size() == 0, "ferr_seen", q.size(), 0);
    i_rx = 1'b1;
    #(20*TCLK);
    chk(o_busy == 1'b0, "break_released", o_busy, 0);
    align();
    send_frame(8'h12, NOMBIT, 1'b1);
    wait_drain("drain_after_break");

    // 5: reset during data bit 4 of 0xC3
    align();
    bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      i_rx = bits[i];
      #(NOMBIT);
    end
    i_rx = bits[5];
    #(NOMBIT/2);
    i_reset = 1'b0;
    #1;
    chk(o_Byte == 8'h00, "midreset_byte", o_Byte, 0);
    chk(o_busy == 1'b0, "midreset_busy", o_busy, 0);
    chk(o_ready_read == 1'b0, "midreset_ready", o_ready_read, 0);
    i_rx = 1'b1;
    #(20*TCLK);
    align();
    i_reset = 1'b1;
    repeat (150) @(negedge clk);
    chk(q.size() == 0 && o_Byte == 8'h00, "midreset_no_strobe", o_Byte, 0);
    align();
    send_frame(8'h3C, NOMBIT, 1'b1);
    wait_drain("drain_3c");

    // 6: +/-2% baud
    align();
    send_frame(8'h00, NOMBIT - 2, 1'b1);
    send_frame(8'hFF, NOMBIT - 2, 1'b1);
    wait_drain("drain_fast");
    align();
    send_frame(8'h00, NOMBIT + 2, 1'b1);
    send_frame(8'hFF, NOMBIT + 2, 1'b1);
    wait_drain("drain_slow");

    // Randomized frames: random data, baud within +/-2%, random idle gaps.
    align();
    for (int n = 0; n < 24; n++) begin
      rb  = 8'($urandom);
      bp  = NOMBIT - 2 + 2 * $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        #(gap * NOMBIT);
        align();
      end
      send_frame(rb, bp, 1'b1);
    end
    wait_drain("drain_random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
